// File: rtl/hero_write_rx.sv
// Frames hero write beats into transactions, buffers them and presents them valid/ready.
// Latency: 1 cycle from qualified beat to FIFO head. Backpressure: none upstream; a full FIFO drops the beat and flags overflow.
// Optional HERO_WRITE_RX_STATS_EN builds the live closed-transaction counter on txn_count_o.

module hero_write_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic [W-1:0]                 in_dat,
    output logic                         in_drop,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [W-1:0]                 out_dat,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          full, pop, push_ok;

    assign full    = (cnt == FULL_CNT);
    assign out_vld = (cnt != '0);
    assign pop     = out_vld & out_rdy;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok = in_vld & (~full | pop);
    assign in_drop = in_vld & full & ~pop;
    assign out_dat = out_vld ? mem[rd_ptr] : '0;
    assign fill    = cnt;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= in_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module hero_write_rx #(
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [45:0]                    hero_wr_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [35:0]                    out_wdat_o,
    output logic [6:0]                     out_sub_o,
    output logic                           out_last_o,
    output logic [$clog2(MAX_BEATS)-1:0]   out_beat_idx_o,
    output logic [$clog2(DEPTH+1)-1:0]     fill_o,
    output logic [15:0]                    txn_count_o,
    input  logic                           err_clr_i,
    output logic                           err_illegal_o,
    output logic                           err_len_o,
    output logic                           err_overflow_o
);
    localparam int IW = $clog2(MAX_BEATS);
    localparam int EW = 36 + 7 + 1 + IW;
    localparam logic [1:0] CT_VALID   = 2'd1;
    localparam logic [1:0] CT_DONE    = 2'd2;
    localparam logic [1:0] CT_ILLEGAL = 2'd3;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;
    localparam logic [IW-1:0] IDX_MAX = IW'(MAX_BEATS - 1);

    logic [1:0]    ct;
    logic [35:0]   wdat;
    logic [6:0]    sub;
    logic          en;
    logic [1:0]    state, nxt_state;
    logic [IW-1:0] idx_q, nxt_idx, push_idx;
    logic          push, push_last, txn_inc, len_set, ill_set, ovf_set;
    logic [EW-1:0] head_dat;

    assign ct   = hero_wr_i[45:44];
    assign wdat = hero_wr_i[43:8];
    assign sub  = hero_wr_i[7:1];
    assign en   = hero_wr_i[0];

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_idx  = '0;
        nxt_state = state;
        nxt_idx   = idx_q;
        txn_inc   = 1'b0;
        len_set   = 1'b0;
        ill_set   = 1'b0;
        if (en) begin
            if (ct == CT_ILLEGAL) begin
                ill_set = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ct == CT_VALID) begin
                            push      = 1'b1;
                            nxt_idx   = '0;
                            nxt_state = ST_ACTIVE;
                        end else if (ct == CT_DONE) begin
                            push      = 1'b1;
                            push_last = 1'b1;
                            txn_inc   = 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        push_idx = idx_q + 1'b1;
                        if (ct == CT_VALID) begin
                            push    = 1'b1;
                            nxt_idx = push_idx;
                            // The final permitted beat closes the transaction itself.
                            if (push_idx == IDX_MAX) begin
                                push_last = 1'b1;
                                len_set   = 1'b1;
                                txn_inc   = 1'b1;
                                nxt_state = ST_DROP;
                            end
                        end else if (ct == CT_DONE) begin
                            push      = 1'b1;
                            push_last = 1'b1;
                            txn_inc   = 1'b1;
                            nxt_state = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (ct == CT_DONE) nxt_state = ST_IDLE;
                    end
                    default: nxt_state = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx_q          <= '0;
            err_illegal_o  <= 1'b0;
            err_len_o      <= 1'b0;
            err_overflow_o <= 1'b0;
        end else begin
            state          <= nxt_state;
            idx_q          <= nxt_idx;
            err_illegal_o  <= (err_illegal_o  & ~err_clr_i) | ill_set;
            err_len_o      <= (err_len_o      & ~err_clr_i) | len_set;
            err_overflow_o <= (err_overflow_o & ~err_clr_i) | ovf_set;
        end
    end

    hero_write_rx_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push),
        .in_dat  ({wdat, sub, push_last, push_idx}),
        .in_drop (ovf_set),
        .out_vld (out_valid_o),
        .out_rdy (out_ready_i),
        .out_dat (head_dat),
        .fill    (fill_o)
    );

    assign out_wdat_o     = head_dat[EW-1 -: 36];
    assign out_sub_o      = head_dat[IW+7 -: 7];
    assign out_last_o     = head_dat[IW];
    assign out_beat_idx_o = head_dat[IW-1:0];

`ifdef HERO_WRITE_RX_STATS_EN
    logic [15:0] txn_q;
    always_ff @(posedge clk) begin
        if (rst)          txn_q <= '0;
        else if (txn_inc) txn_q <= txn_q + 1'b1;
    end
    assign txn_count_o = txn_q;
`else
    logic txn_unused;
    assign txn_unused  = txn_inc;
    assign txn_count_o = '0;
`endif
endmodule

// File: doc/hero_write_rx.md
# hero_write_rx

Receive stage that sits directly downstream of a hero write bus driver and consumes `test_pkg_a_rypkg::hero_write_t` beats. The hero bus has no backpressure, so this block frames beats into transactions (`VALID`… `DONE`), buffers them in a DEPTH-entry FIFO, and presents them on a valid/ready interface with a last flag and beat index. It detects illegal cycle types, over-length transactions and buffer overflow, and reports each as a sticky error.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries, power of 2, ≥2.
- `MAX_BEATS`, default 16: maximum beats per transaction, power of 2, ≥2.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `hero_wr_i`  in  46  `hero_write_t` beat: `cycle_type`, `wdat`, `another_type_reference`, `clk_en`.
- `out_valid_o`  out  1  head FIFO entry valid.
- `out_ready_i`  in  1  downstream accepts the head entry.
- `out_wdat_o`  out  36  head entry `wdat`.
- `out_sub_o`  out  7  head entry `sub_def_t`.
- `out_last_o`  out  1  head entry is the final beat of its transaction.
- `out_beat_idx_o`  out  clog2(MAX_BEATS)  head entry beat index within its transaction.
- `fill_o`  out  clog2(DEPTH+1)  FIFO occupancy.
- `txn_count_o`  out  16  count of closed transactions.
- `err_clr_i`  in  1  one-cycle pulse that clears all sticky errors.
- `err_illegal_o`  out  1  sticky: `cycle_type` value 3 was received.
- `err_len_o`  out  1  sticky: transaction exceeded MAX_BEATS.
- `err_overflow_o`  out  1  sticky: beat arrived while the FIFO was full.

## Operation
- Beat qualified only when `clk_en`=1. With `clk_en`=0 the input is ignored entirely: no state change and no errors.
- FSM states:
  - IDLE (reset state).
  - ACTIVE: transaction open.
  - DROP: discarding the remainder of an over-length transaction.
- IDLE:
  - VALID: push beat with idx 0 and last=0; go to ACTIVE.
  - DONE: push beat with idx 0 and last=1; `txn_count`+1; stay in IDLE.
- ACTIVE:
  - VALID: push beat with idx+1.
  - DONE: push beat with idx+1 and last=1; `txn_count`+1; go to IDLE.
  - IDLE cycles: stay in ACTIVE. Gaps in a transaction are legal.
- Length limit: a VALID beat at idx MAX_BEATS-1 is pushed with last=1, `err_len` is set, `txn_count`+1, and the FSM goes to DROP.
- DROP: discard all beats. DONE returns the FSM to IDLE without pushing and without counting.
- `cycle_type`=3 (qualified): beat discarded, `err_illegal` set, FSM unchanged.
- Full FIFO:
  - A push with the FIFO full and no pop in the same cycle is dropped and sets `err_overflow`.
  - The FSM, beat index and `txn_count` still advance as if the beat had been stored.
  - Full with a pop in the same cycle: the push succeeds.
- Pop: the head entry leaves when `out_valid_o && out_ready_i`. Simultaneous push and pop leaves `fill_o` unchanged.
- `txn_count_o` wraps from 0xFFFF to 0.
- Errors: set and clear in the same cycle → set wins.

## Timing
- Beat sampled at edge N appears at the head of an empty FIFO with `out_valid_o`=1 after edge N (1-cycle latency).
- `fill_o` and `txn_count_o` update on the same edge as the push or pop that changes them.
- Downstream handshake rules:
  - `out_*` must hold stable while `out_valid_o`=1 and `out_ready_i`=0.
  - `out_valid_o` must not depend combinationally on `out_ready_i`.
- Throughput: 1 beat per cycle in and out.
- Reset values:
  - `out_valid_o`=0, `fill_o`=0, `txn_count_o`=0.
  - All error outputs 0.
  - `out_last_o`=0, `out_beat_idx_o`=0, `out_wdat_o`=0, `out_sub_o`=0.
  - FSM in IDLE.
- Reset mid-transaction discards FIFO contents and the open transaction. The next qualified beat is treated as arriving in IDLE.

## Configuration
- `HERO_WRITE_RX_STATS_EN` defined: `txn_count_o` is a live 16-bit counter.
- Not defined: the counter is not built and `txn_count_o` is tied to 0. Framing, FIFO and error behaviour are identical.

## Test plan
- Send VALID×3 then DONE with `out_ready_i`=1 → 4 outputs with idx 0,1,2,3; last only on idx 3; `txn_count_o`=1 (stats on).
- Single DONE from IDLE → one output with idx 0 and last=1; FSM stays in IDLE.
- Send 18 VALIDs then DONE with MAX_BEATS=16 → 16 outputs, last on idx 15; `err_len_o`=1; beats 17–18 and the DONE produce no output; `txn_count_o`=1.
- `out_ready_i`=0, push 9 beats with DEPTH=8 → `fill_o`=8; `err_overflow_o`=1; the 9th beat is absent; with `out_ready_i`=1 the 8 stored beats drain in order.
- `cycle_type`=3 with `clk_en`=1 → `err_illegal_o`=1, no push. Same input with `clk_en`=0 → no effect. Pulse `err_clr_i` → 0. `err_clr_i` coinciding with a new error → error stays 1.
- Assert `rst` after 2 VALIDs → outputs at reset values. Next DONE → single-beat transaction with idx 0.
